// File: rtl/spi_reg_ctrl_pkg.sv
// Shared definitions for the SPI frame-to-register-bus controller:
// FSM encoding, command opcodes and the STATUS byte returned at frame start.
package spi_reg_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_WR   = 3'd3,
        S_RD   = 3'd4,
        S_DROP = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_WR  = 2'b01,
        OP_RD  = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    localparam logic [3:0] STATUS_NIB = 4'hA;
    localparam logic [7:0] FILL_BYTE  = 8'hFF;

    function automatic logic [7:0] status_byte(input logic err_flag);
        return {STATUS_NIB, 3'b000, err_flag};
    endfunction

endpackage

// File: rtl/spi_reg_ctrl.sv
// Frame-level controller: turns SPI core byte strobes into single-cycle
// register-bus reads/writes with auto-incrementing address and MISO prefetch.
module spi_reg_ctrl
    import spi_reg_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] user_out,
    input  logic       user_out_stb,
    output logic [7:0] user_in,
    input  logic       user_in_ack,
    input  logic       csn_state,
    input  logic       csn_fall,
    input  logic       csn_rise,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic       err
);

    state_t     state_q, state_d;
    logic       op_rd_q, op_rd_d;
    logic [7:0] addr_q, addr_d;
    logic       rd_vld_p1, rd_vld_d;

    logic [7:0] user_in_d;
    logic [7:0] bus_addr_d;
    logic [7:0] bus_wdata_d;
    logic       bus_we_d;
    logic       bus_re_d;
    logic       err_d;

    logic       live;
    logic       byte_stb;
    logic       wr_fire;
    logic       rd_entry;
    logic       rd_next;
    logic       rd_load;
    op_t        op;

    assign op = op_t'(user_out[7:6]);

    // Any chip-select event in this cycle masks the byte/ack inputs, so a
    // strobe coinciding with frame end never reaches the bus.
    assign live     = ~(csn_rise | csn_fall | csn_state);
    assign byte_stb = user_out_stb & live;
    assign wr_fire  = byte_stb & (state_q == S_WR);
    assign rd_entry = byte_stb & (state_q == S_ADDR) & op_rd_q;
    assign rd_next  = user_in_ack & live & (state_q == S_RD);
    assign rd_load  = rd_vld_p1 & live & (state_q == S_RD);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_rd_q   <= 1'b0;
            addr_q    <= 8'h00;
            rd_vld_p1 <= 1'b0;
            user_in   <= status_byte(1'b0);
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_rd_q   <= op_rd_d;
            addr_q    <= addr_d;
            rd_vld_p1 <= rd_vld_d;
            user_in   <= user_in_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
            bus_we    <= bus_we_d;
            bus_re    <= bus_re_d;
            err       <= err_d;
        end
    end

    // Next-state logic; frame end has priority over everything else
    always_comb begin
        state_d = state_q;
        if (csn_rise) begin
            state_d = S_IDLE;
        end else if (csn_fall) begin
            state_d = S_CMD;
        end else if (csn_state) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_CMD: begin
                    if (user_out_stb) begin
                        if (op == OP_WR || op == OP_RD) state_d = S_ADDR;
                        else                            state_d = S_DROP;
                    end
                end
                S_ADDR: begin
                    if (user_out_stb) state_d = op_rd_q ? S_RD : S_WR;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        op_rd_d     = op_rd_q;
        addr_d      = addr_q;
        err_d       = err;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        bus_we_d    = wr_fire;
        bus_re_d    = rd_entry | rd_next;
        // Returning read data is dropped if the frame ended while it was in flight
        rd_vld_d    = bus_re & live;

        if (byte_stb && state_q == S_CMD) begin
            op_rd_d = (op == OP_RD);
            if (op == OP_NOP) err_d = 1'b0;
            if (op == OP_RSV) err_d = 1'b1;
        end

        if (byte_stb && state_q == S_ADDR) begin
            addr_d = user_out;
        end

        if (wr_fire) begin
            bus_addr_d  = addr_q;
            bus_wdata_d = user_out;
            addr_d      = addr_q + 8'd1;
        end

        if (rd_entry) begin
            bus_addr_d = user_out;
        end

        if (rd_next) begin
            bus_addr_d = addr_q + 8'd1;
            addr_d     = addr_q + 8'd1;
        end

        case (state_d)
            S_IDLE, S_CMD: user_in_d = status_byte(err_d);
            S_RD: begin
                if (state_q != S_RD) user_in_d = FILL_BYTE;
                else if (rd_load)    user_in_d = bus_rdata;
                else                 user_in_d = user_in;
            end
            default:       user_in_d = FILL_BYTE;
        endcase
    end

endmodule
